// File: rtl/div_sequencer_if.sv
// Handshake and core-side bundle for the divide sequencer.
// slave: sequencer view; master: requester/consumer/core view.
interface div_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic [31:0] out_r;
    logic        out_dz;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_d;
    logic [31:0] div_r;
    logic        div_ok;

    modport slave (
        input  in_valid, in_a, in_b, in_signed,
        output in_ready,
        output out_valid, out_q, out_r, out_dz,
        input  out_ready,
        output div_start, div_a, div_b,
        input  div_d, div_r, div_ok
    );

    modport master (
        output in_valid, in_a, in_b, in_signed,
        input  in_ready,
        input  out_valid, out_q, out_r, out_dz,
        output out_ready,
        input  div_start, div_a, div_b,
        output div_d, div_r, div_ok
    );
endinterface

// File: rtl/div_sequencer.sv
// Front/back end for the 32-bit iterative unsigned divider core.
// Ports: clk, reset (async, active-high), bus (request, result, core).
module div_sequencer (
    input  logic          clk,
    input  logic          reset,
    div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, CAP, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        vld_q, vld_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;

    logic        a_neg, b_neg;

    assign a_neg = bus.in_signed & bus.in_a[31];
    assign b_neg = bus.in_signed & bus.in_b[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            vld_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            vld_q   <= vld_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        vld_d   = vld_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    a_d    = a_neg ? -bus.in_a : bus.in_a;
                    b_d    = b_neg ? -bus.in_b : bus.in_b;
                    if (bus.in_b == '0) begin
                        // Divide-by-zero is answered locally.
                        quo_d   = '1;
                        rem_d   = bus.in_a;
                        dz_d    = 1'b1;
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        start_d = 1'b1;
                        cnt_d   = 6'd32;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Start is held for 1 load + 32 iteration edges and
                // drops before the core reports idle again.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    start_d = 1'b0;
                    state_d = CAP;
                end
            end
            CAP: begin
                quo_d   = negq_q ? -bus.div_d : bus.div_d;
                rem_d   = negr_q ? -bus.div_r : bus.div_r;
                dz_d    = 1'b0;
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = vld_q;
    assign bus.out_q     = quo_q;
    assign bus.out_r     = rem_q;
    assign bus.out_dz    = dz_q;
    assign bus.div_start = start_q;
    assign bus.div_a     = a_q;
    assign bus.div_b     = b_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider core.
// Vector table plus backpressure and mid-run reset sequences.
module tb_div_sequencer;
    logic clk;
    logic reset;

    div_sequencer_if bus();

    div_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Behavioural iterative core: load on start while idle,
    // then 32 busy edges before results and div_ok return.
    logic [31:0] c_a, c_b;
    logic [5:0]  c_it;
    int          starts;
    int          loads;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.div_ok <= 1'b1;
            bus.div_d  <= '0;
            bus.div_r  <= '0;
            c_it       <= '0;
        end else if (c_it != 0) begin
            c_it <= c_it - 6'd1;
            if (c_it == 6'd1) begin
                bus.div_ok <= 1'b1;
                bus.div_d  <= c_a / c_b;
                bus.div_r  <= c_a % c_b;
            end
        end else if (bus.div_start && bus.div_ok) begin
            c_a        <= bus.div_a;
            c_b        <= bus.div_b;
            bus.div_ok <= 1'b0;
            c_it       <= 6'd32;
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.div_start) begin
            starts++;
            if (bus.div_ok && c_it == 0) loads++;
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vt[11];

    // Issue one request with out_ready held high; checks latency,
    // result, start-edge count and the single-cycle valid pulse.
    task automatic do_op(input vec_t v, input string nm);
        int n;
        chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
        starts = 0;
        loads  = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_signed = v.sgn;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, v.dz ? 32'd1 : 32'd35);
        chk({nm, " q"}, bus.out_q, v.q);
        chk({nm, " r"}, bus.out_r, v.r);
        chk({nm, " dz"}, 32'(bus.out_dz), 32'(v.dz));
        chk({nm, " starts"}, starts, v.dz ? 32'd0 : 32'd33);
        chk({nm, " loads"}, loads, v.dz ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        chk({nm, " pulse"}, 32'(bus.out_valid), 32'd0);
        chk({nm, " ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [31:0] hq, hr;
        int n;
        n_chk  = 0;
        n_fail = 0;
        starts = 0;
        loads  = 0;

        vt[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
        vt[1]  = '{32'hFFFFFFF9, 32'd2, 1'b1,
                   32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vt[2]  = '{32'd7, 32'hFFFFFFFE, 1'b1,
                   32'hFFFFFFFD, 32'd1, 1'b0};
        vt[3]  = '{32'hFFFFFFF9, 32'd2, 1'b0,
                   32'h7FFFFFFC, 32'd1, 1'b0};
        vt[4]  = '{32'd7, 32'hFFFFFFFE, 1'b0, 32'd0, 32'd7, 1'b0};
        vt[5]  = '{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1};
        vt[6]  = '{32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1};
        vt[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
                   32'h80000000, 32'd0, 1'b0};
        vt[8]  = '{32'hFFFFFFFF, 32'd1, 1'b0,
                   32'hFFFFFFFF, 32'd0, 1'b0};
        vt[9]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1,
                   32'd14, 32'hFFFFFFFE, 1'b0};
        vt[10] = '{32'hFFFFFFFB, 32'd0, 1'b1,
                   32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst div_start", 32'(bus.div_start), 32'd0);
        chk("rst out_q", bus.out_q, 32'd0);
        chk("rst out_r", bus.out_r, 32'd0);
        chk("rst out_dz", 32'(bus.out_dz), 32'd0);
        chk("rst div_a", bus.div_a, 32'd0);
        chk("rst div_b", bus.div_b, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: each op starts the cycle after the handshake.
        for (int i = 0; i < 11; i++) begin
            do_op(vt[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold result for 10 cycles.
        starts = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd100;
        bus.in_b      = 32'd7;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp latency", n, 32'd35);
        hq = bus.out_q;
        hr = bus.out_r;
        chk("bp q", hq, 32'd14);
        chk("bp r", hr, 32'd2);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp valid", 32'(bus.out_valid), 32'd1);
            chk("bp hold q", bus.out_q, 32'd14);
            chk("bp hold r", bus.out_r, 32'd2);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp start", 32'(bus.div_start), 32'd0);
        end
        chk("bp starts", starts, 32'd33);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release", 32'(bus.out_valid), 32'd0);
        chk("bp idle", 32'(bus.in_ready), 32'd1);

        // Reset during RUN, then a fresh divide.
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd100;
        bus.in_b     = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
        end
        chk("mid start", 32'(bus.div_start), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr start", 32'(bus.div_start), 32'd0);
        chk("mr valid", 32'(bus.out_valid), 32'd0);
        chk("mr div_a", bus.div_a, 32'd0);
        chk("mr div_b", bus.div_b, 32'd0);
        chk("mr out_q", bus.out_q, 32'd0);
        chk("mr in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        v = vt[0];
        do_op(v, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
